btn_debounce_edge: RTL and testbench

// - Front-end for the PYNQ push-buttons (BTN1..BTN3). Sits between the raw pads and led_twinkle.
// - Synchronises each button, then debounces it with a per-key counter FSM.
// - Produces a clean level, one-cycle press/release pulses and a one-shot long-press pulse.
// - The LED controller consumes only these outputs, never raw pads.

---
 rtl/pynq_key_pkg.sv | 16 +
 rtl/btn_debounce_edge_if.sv | 30 +++
 rtl/btn_debounce_edge_ch.sv | 91 +++++++++
 rtl/btn_debounce_edge.sv | 41 ++++
 tb/tb_btn_debounce_edge.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pynq_key_pkg.sv
// rtl/pynq_key_pkg.sv - shared key front-end defaults and per-key FSM encoding
package pynq_key_pkg;

   localparam int DEF_N_KEYS            = 3;
   localparam int DEF_DEBOUNCE_CYCLES   = 2_500_000;
   localparam int DEF_LONG_PRESS_CYCLES = 125_000_000;
   localparam int DEF_CNT_W             = 27;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } key_state_t;

endpackage

// File: rtl/btn_debounce_edge_if.sv
// rtl/btn_debounce_edge_if.sv - raw pads in, debounced level and event pulses out
interface btn_debounce_edge_if
   import pynq_key_pkg::*;
#(
   parameter int N_KEYS = DEF_N_KEYS
);

   logic [N_KEYS-1:0] key_raw;
   logic [N_KEYS-1:0] key_level;
   logic [N_KEYS-1:0] key_press;
   logic [N_KEYS-1:0] key_release;
   logic [N_KEYS-1:0] key_long;

   modport master (
      output key_raw,
      input  key_level,
      input  key_press,
      input  key_release,
      input  key_long
   );

   modport slave (
      input  key_raw,
      output key_level,
      output key_press,
      output key_release,
      output key_long
   );

endinterface

// File: rtl/btn_debounce_edge_ch.sv
// rtl/btn_debounce_edge_ch.sv - one key: 2-FF synchroniser, debounce FSM, hold timer, pulse regs
module btn_debounce_ch
   import pynq_key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
   parameter int CNT_W             = DEF_CNT_W
) (
   input  logic sys_clk,
   input  logic sys_rstn,
   input  logic key_raw,
   output logic key_level,
   output logic key_press,
   output logic key_release,
   output logic key_long
);

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_PRE  = CNT_W'(LONG_PRESS_CYCLES - 2);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic             sync_ff1;
   logic             key_sync;
   key_state_t       state;
   logic [CNT_W-1:0] db_cnt;
   logic [CNT_W-1:0] hold_cnt;

   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         sync_ff1    <= 1'b0;
         key_sync    <= 1'b0;
         state       <= IDLE;
         db_cnt      <= '0;
         hold_cnt    <= '0;
         key_level   <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
         key_long    <= 1'b0;
      end else begin
         sync_ff1    <= key_raw;
         key_sync    <= sync_ff1;
         key_press   <= 1'b0;
         key_release <= 1'b0;
         key_long    <= 1'b0;
         case (state)
            IDLE: begin
               if (key_sync) begin
                  state  <= PRESS_WAIT;
                  db_cnt <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!key_sync) begin
                  state <= IDLE;
               end else if (db_cnt == DB_LAST) begin
                  state     <= PRESSED;
                  key_press <= 1'b1;
                  key_level <= 1'b1;
               end else begin
                  db_cnt <= db_cnt + CNT_ONE;
               end
            end
            PRESSED: begin
               if (!key_sync) begin
                  state  <= RELEASE_WAIT;
                  db_cnt <= '0;
               end else if (hold_cnt != HOLD_LAST) begin
                  // hold_cnt saturates at HOLD_LAST, so the long pulse cannot repeat
                  hold_cnt <= hold_cnt + CNT_ONE;
                  key_long <= (hold_cnt == HOLD_PRE);
               end
            end
            RELEASE_WAIT: begin
               if (key_sync) begin
                  state <= PRESSED;
               end else if (db_cnt == DB_LAST) begin
                  state       <= IDLE;
                  key_release <= 1'b1;
                  key_level   <= 1'b0;
                  hold_cnt    <= '0;
               end else begin
                  db_cnt <= db_cnt + CNT_ONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/btn_debounce_edge.sv
// rtl/btn_debounce_edge.sv - N_KEYS independent debounce channels behind one interface
module btn_debounce_edge
   import pynq_key_pkg::*;
#(
   parameter int N_KEYS            = DEF_N_KEYS,
   parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
   parameter int CNT_W             = DEF_CNT_W
) (
   input  logic          sys_clk,
   input  logic          sys_rstn,
   btn_debounce_edge_if.slave bus
);

   logic [N_KEYS-1:0] level_w;
   logic [N_KEYS-1:0] press_w;
   logic [N_KEYS-1:0] release_w;
   logic [N_KEYS-1:0] long_w;

   for (genvar i = 0; i < N_KEYS; i++) begin : g_key
      btn_debounce_ch #(
         .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
         .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
         .CNT_W             (CNT_W)
      ) u_ch (
         .sys_clk     (sys_clk),
         .sys_rstn    (sys_rstn),
         .key_raw     (bus.key_raw[i]),
         .key_level   (level_w[i]),
         .key_press   (press_w[i]),
         .key_release (release_w[i]),
         .key_long    (long_w[i])
      );
   end

   assign bus.key_level   = level_w;
   assign bus.key_press   = press_w;
   assign bus.key_release = release_w;
   assign bus.key_long    = long_w;

endmodule

// File: tb/tb_btn_debounce_edge.sv
// tb/tb_btn_debounce_edge.sv - randomized and directed checks against a run-length key model
module tb_btn_debounce_edge;

   localparam int NK = 3;
   localparam int DB = 8;
   localparam int LP = 40;

   logic sys_clk;
   logic sys_rstn;

   btn_debounce_edge_if #(.N_KEYS(NK)) bus ();

   btn_debounce_edge #(
      .N_KEYS            (NK),
      .DEBOUNCE_CYCLES   (DB),
      .LONG_PRESS_CYCLES (LP),
      .CNT_W             (27)
   ) dut (
      .sys_clk  (sys_clk),
      .sys_rstn (sys_rstn),
      .bus      (bus)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int checks = 0;
   int errors = 0;

   // Model: a level flips once the synchronised input has disagreed with it
   // for DB+1 consecutive edges; hold time counts agreeing edges while pressed.
   logic [NK-1:0] m_s1, m_s2, m_lvl, m_press, m_rel, m_long;
   int run [NK];
   int hold[NK];

   task automatic model_clear();
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_rel = '0; m_long = '0;
      for (int k = 0; k < NK; k++) begin
         run[k] = 0;
         hold[k] = 0;
      end
   endtask

   task automatic model_edge();
      logic [NK-1:0] sync_now;
      sync_now = m_s2;
      m_press = '0; m_rel = '0; m_long = '0;
      for (int k = 0; k < NK; k++) begin
         if (sync_now[k] != m_lvl[k]) begin
            run[k]++;
            if (run[k] == DB + 1) begin
               m_lvl[k] = sync_now[k];
               run[k] = 0;
               if (sync_now[k]) m_press[k] = 1'b1;
               else begin
                  m_rel[k] = 1'b1;
                  hold[k] = 0;
               end
            end
         end else begin
            if (m_lvl[k] && run[k] == 0 && hold[k] < LP - 1) begin
               hold[k]++;
               if (hold[k] == LP - 1) m_long[k] = 1'b1;
            end
            run[k] = 0;
         end
      end
      m_s2 = m_s1;
      m_s1 = bus.key_raw;
   endtask

   function automatic logic [4*NK-1:0] exp_vec();
      return {m_lvl, m_press, m_rel, m_long};
   endfunction

   function automatic logic [4*NK-1:0] dut_vec();
      return {bus.key_level, bus.key_press, bus.key_release, bus.key_long};
   endfunction

   task automatic step(input logic [NK-1:0] raw);
      bus.key_raw = raw;
      @(posedge sys_clk);
      if (!sys_rstn) model_clear();
      else model_edge();
      @(negedge sys_clk);
   endtask

   task automatic settle();
      for (int i = 0; i < DB + 6; i++) step('0);
   endtask

   task automatic test_reset();
      int press_at;
      logic [NK-1:0] press_val;
      sys_rstn = 1'b0;
      bus.key_raw = 3'b111;
      model_clear();
      repeat (3) @(negedge sys_clk);
      checks++;
      if (dut_vec() !== '0)
         $display("FAIL reset_outputs got %h want 0", dut_vec());
      if (dut_vec() !== '0) errors++;
      sys_rstn = 1'b1;
      press_at = 0;
      press_val = '0;
      for (int i = 1; i <= 20; i++) begin
         step(3'b111);
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_release_cyc%0d got %h want %h", i, dut_vec(), exp_vec());
         end
         if (press_at == 0 && bus.key_press != 0) begin
            press_at = i;
            press_val = bus.key_press;
         end
      end
      checks++;
      if (press_at != DB + 3 || press_val !== 3'b111) begin
         errors++;
         $display("FAIL reset_press_latency got edge %0d val %b want edge %0d val 111", press_at, press_val, DB + 3);
      end
      checks++;
      if (bus.key_level !== 3'b111) begin
         errors++;
         $display("FAIL reset_level got %b want 111", bus.key_level);
      end
      settle();
   endtask

   task automatic test_bounce();
      int pulses;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         step((i < 30 && (i / 3) % 2 == 0) ? 3'b001 : 3'b000);
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL bounce_cyc%0d got %h want %h", i, dut_vec(), exp_vec());
         end
         if (bus.key_press[0] || bus.key_release[0] || bus.key_level[0]) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL bounce_activity got %0d want 0", pulses);
      end
   endtask

   task automatic test_clean_press();
      int press_at, long_at, rel_at, n_long;
      press_at = 0; long_at = 0; rel_at = 0; n_long = 0;
      for (int i = 1; i <= 75; i++) begin
         step(i <= 50 ? 3'b010 : 3'b000);
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL clean_cyc%0d got %h want %h", i, dut_vec(), exp_vec());
         end
         if (bus.key_press[1] && press_at == 0) press_at = i;
         if (bus.key_long[1]) begin
            n_long++;
            long_at = i;
         end
         if (bus.key_release[1] && rel_at == 0) rel_at = i;
      end
      checks++;
      if (press_at != DB + 3) begin
         errors++;
         $display("FAIL clean_press_edge got %0d want %0d", press_at, DB + 3);
      end
      checks++;
      if (n_long != 1 || long_at != DB + 3 + LP - 1) begin
         errors++;
         $display("FAIL clean_long got count %0d edge %0d want 1 edge %0d", n_long, long_at, DB + 3 + LP - 1);
      end
      checks++;
      if (rel_at != 50 + DB + 3) begin
         errors++;
         $display("FAIL clean_release_edge got %0d want %0d", rel_at, 50 + DB + 3);
      end
   endtask

   task automatic test_release_bounce();
      int events;
      for (int i = 0; i < DB + 6; i++) step(3'b100);
      events = 0;
      for (int i = 0; i < 20; i++) begin
         step((i >= 2 && i < 6) ? 3'b000 : 3'b100);
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL relbounce_cyc%0d got %h want %h", i, dut_vec(), exp_vec());
         end
         if (bus.key_release[2] || bus.key_press[2] || !bus.key_level[2]) events++;
      end
      checks++;
      if (events != 0) begin
         errors++;
         $display("FAIL relbounce_events got %0d want 0", events);
      end
      settle();
   endtask

   task automatic test_independence();
      int press_at;
      logic [NK-1:0] press_val;
      int k1_events;
      press_at = 0; press_val = '0; k1_events = 0;
      for (int i = 1; i <= 15; i++) begin
         step(3'b101);
         if (bus.key_press != 0 && press_at == 0) begin
            press_at = i;
            press_val = bus.key_press;
         end
         if (bus.key_press[1] || bus.key_level[1] || bus.key_release[1] || bus.key_long[1]) k1_events++;
      end
      checks++;
      if (press_at != DB + 3 || press_val !== 3'b101 || k1_events != 0) begin
         errors++;
         $display("FAIL independence got edge %0d val %b k1 %0d want edge %0d val 101 k1 0",
                  press_at, press_val, k1_events, DB + 3);
      end
      settle();
   endtask

   task automatic test_mid_reset();
      int press_at, rel_seen;
      for (int i = 0; i < 5; i++) step(3'b001);
      sys_rstn = 1'b0;
      model_clear();
      #1;
      checks++;
      if (dut_vec() !== '0) begin
         errors++;
         $display("FAIL midreset_pw got %h want 0", dut_vec());
      end
      step(3'b001);
      step(3'b001);
      sys_rstn = 1'b1;
      press_at = 0;
      for (int i = 1; i <= 20; i++) begin
         step(3'b001);
         if (bus.key_press[0] && press_at == 0) press_at = i;
      end
      checks++;
      if (press_at != DB + 3 || bus.key_level !== 3'b001) begin
         errors++;
         $display("FAIL midreset_held_press got edge %0d level %b want edge %0d level 001", press_at, bus.key_level, DB + 3);
      end
      sys_rstn = 1'b0;
      model_clear();
      #1;
      checks++;
      if (dut_vec() !== '0) begin
         errors++;
         $display("FAIL midreset_pressed got %h want 0", dut_vec());
      end
      step(3'b000);
      step(3'b000);
      sys_rstn = 1'b1;
      rel_seen = 0;
      for (int i = 0; i < 20; i++) begin
         step(3'b000);
         if (dut_vec() !== exp_vec() || bus.key_release != 0) rel_seen++;
      end
      checks++;
      if (rel_seen != 0) begin
         errors++;
         $display("FAIL midreset_no_release got %0d bad cycles want 0", rel_seen);
      end
      press_at = 0;
      for (int i = 1; i <= 15; i++) begin
         step(3'b001);
         if (bus.key_press[0] && press_at == 0) press_at = i;
      end
      checks++;
      if (press_at != DB + 3) begin
         errors++;
         $display("FAIL midreset_repress got edge %0d want %0d", press_at, DB + 3);
      end
      settle();
   endtask

   task automatic test_random();
      logic [NK-1:0] raw;
      int dur, pulses, bad;
      pulses = 0; bad = 0;
      for (int seg = 0; seg < 60; seg++) begin
         raw = NK'($urandom_range(0, 7));
         dur = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 60) : $urandom_range(1, 12);
         for (int c = 0; c < dur; c++) begin
            step(raw);
            checks++;
            if (dut_vec() !== exp_vec()) begin
               errors++;
               bad++;
               if (bad <= 10)
                  $display("FAIL random_seg%0d_cyc%0d got %h want %h", seg, c, dut_vec(), exp_vec());
            end
            if (m_press != 0 || m_rel != 0 || m_long != 0) pulses++;
         end
      end
      checks++;
      if (pulses == 0) begin
         errors++;
         $display("FAIL random_activity got 0 model events want >0");
      end
      settle();
   endtask

   initial begin
      bus.key_raw = '0;
      sys_rstn = 1'b0;
      test_reset();
      test_bounce();
      test_clean_press();
      test_release_bounce();
      test_independence();
      test_mid_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule
